multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Five-stage FSM that sequences the multi-cycle RISC-V datapath. It replaces the free-running cycle counter with opcode-dependent stage lengths and memory-ready stalls. It sits beside the control unit and the datapath: it drives instruction-register, PC, register-file and memory enables, while the control unit keeps generating the mux and ALU selects. Retirement is one pulse per instruction.

## Interface
- `TIMEOUT`, default 255: maximum wait cycles for `mem_ready`; 0 disables the watchdog.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `run`  in  1  when low, the sequencer idles in FETCH without starting a fetch.
- `opcode`  in  7  instr[6:0] from the instruction register; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `ir_we`  out  1  load the instruction register.
- `pc_we`  out  1  write the PC (PC+4 or branch target, as selected by PCSel).
- `reg_we`  out  1  register-file write enable.
- `mem_en`  out  1  memory access request.
- `mem_we`  out  1  store (qualifies `mem_en`).
- `stage`  out  3  current state encoding.
- `instr_done`  out  1  retire pulse.
- `mem_timeout`  out  1  one-cycle pulse when the watchdog expires.

## Operation
- Opcode classes:
  - BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011.
  - Any other opcode is ILLEGAL.
- Class latching: the class is latched at the end of DECODE; later `opcode` changes are ignored.
- FETCH (encoding 0):
  - `mem_en` = `run`.
  - On `run` && `mem_ready`: `ir_we`=1, go to DECODE.
- DECODE (1):
  - ILLEGAL: `pc_we`=1, `instr_done`=1, go to FETCH (executes as a NOP).
  - Otherwise: go to EXECUTE.
- EXECUTE (2):
  - BRANCH: `pc_we`=1, `instr_done`=1, go to FETCH.
  - LOAD/STORE: go to MEMORY.
  - OP/OPIMM: go to WRITEBACK.
- MEMORY (3):
  - `mem_en`=1; `mem_we`=1 for STORE.
  - On `mem_ready`, STORE: `pc_we`=1, `instr_done`=1, go to FETCH.
  - On `mem_ready`, LOAD: go to WRITEBACK.
- WRITEBACK (4): `reg_we`=1, `pc_we`=1, `instr_done`=1, go to FETCH.
- Output types:
  - `mem_en`, `mem_we` and `reg_we` are functions of state (plus `run` in FETCH).
  - `ir_we`, `pc_we` and `instr_done` are combinational on state, class and `mem_ready`.
- Watchdog:
  - Counts consecutive cycles with `mem_en` && !`mem_ready`.
  - Expiry is the count reaching `TIMEOUT`:
    - in FETCH: pulse `mem_timeout`, clear the counter, keep requesting;
    - in MEMORY: pulse `mem_timeout`, `pc_we`=1, `instr_done`=1, go to FETCH. No register write occurs.
  - The counter clears on any state change or on `mem_ready`.

## Timing
- Reset:
  - The next state is FETCH, the counters clear and the latched class becomes ILLEGAL.
  - All outputs are forced to 0 while `rst` is high, including mid-instruction.
  - A partially executed instruction is dropped and no retire pulse is emitted.
- Latency with `mem_ready` held high (cycles, FETCH to retire inclusive):
  - ILLEGAL 2, BRANCH 3, OP/OPIMM 4, STORE 4, LOAD 5.
  - Each cycle of `mem_ready` low in FETCH or MEMORY adds one cycle.
- `mem_ready` is ignored outside FETCH and MEMORY, and in FETCH while `run`=0.
- `run` falling:
  - Takes effect only in FETCH; the instruction in flight always completes.
  - If `run` drops in FETCH, no `ir_we` occurs that cycle.
- `instr_done` and `pc_we` always assert together, exactly once per instruction.

## Configuration
- `SEQ_PERF_EN` defined:
  - Adds output `instr_retired` [31:0], incremented on `instr_done`.
  - Adds output `stall_cycles` [31:0], incremented on `mem_en` && !`mem_ready`.
  - Both clear on `rst` and wrap at 2^32.
- `SEQ_PERF_EN` undefined: both ports and both counters are absent; behaviour is otherwise identical.

## Structure
- `cpu_pkg` holds:
  - the opcode localparams shared with the control unit;
  - the state enum (FETCH=0 … WRITEBACK=4);
  - the opcode-class enum.
- Sub-module `opclass_decode` (combinational): `opcode` → class.

## Test plan
- ADD (0110011), `mem_ready`=1 → `ir_we` in cycle 0; `reg_we`, `pc_we` and `instr_done` in cycle 3; back in FETCH in cycle 4.
- LW with `mem_ready` low for 3 MEMORY cycles → `reg_we` in cycle 7; `stall_cycles`=3 when `SEQ_PERF_EN` is defined.
- BEQ, then opcode 0000000 → `pc_we` in cycle 2; the illegal opcode retires in 2 cycles with `reg_we` never asserted.
- `TIMEOUT`=4, SW with `mem_ready` stuck low → `mem_timeout` pulses in MEMORY after 4 waits; `pc_we` and `instr_done` assert, then FETCH.
- `rst` asserted in WRITEBACK → all outputs are 0 that cycle, `reg_we` is suppressed, and `stage`=0 next cycle.
- `run`=0 in FETCH for 5 cycles → `mem_en`=0 throughout; `run`=1 → fetch resumes the same cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode classes for the
// multi-cycle RISC-V core.
package cpu_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_BRANCH  = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_OPIMM   = 3'd4,
    CLS_OP      = 3'd5
  } opclass_t;

endpackage

// File: rtl/opclass_decode.sv
// Combinational opcode-to-class map; anything unrecognised is ILLEGAL.
module opclass_decode
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   opclass
);

  always_comb begin
    opclass = CLS_ILLEGAL;
    case (opcode)
      OPC_BRANCH: opclass = CLS_BRANCH;
      OPC_LOAD:   opclass = CLS_LOAD;
      OPC_STORE:  opclass = CLS_STORE;
      OPC_OPIMM:  opclass = CLS_OPIMM;
      OPC_OP:     opclass = CLS_OP;
      default:    opclass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Five-stage sequencer for the multi-cycle datapath with memory stall watchdog.
// Optional perf counters (instr_retired, stall_cycles) under `SEQ_PERF_EN.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        mem_en,
  output logic        mem_we,
  output logic [2:0]  stage,
  output logic        instr_done,
`ifdef SEQ_PERF_EN
  output logic [31:0] instr_retired,
  output logic [31:0] stall_cycles,
`endif
  output logic        mem_timeout
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  state_t         state, next;
  opclass_t       dec_class, class_q;
  logic [WDW-1:0] wd_cnt;
  logic           stall, expire;
  logic           ir_we_c, pc_we_c, reg_we_c, mem_en_c, mem_we_c, done_c;

  opclass_decode u_dec (
    .opcode  (opcode),
    .opclass (dec_class)
  );

  assign stall  = mem_en_c && !mem_ready;
  // wd_cnt holds prior consecutive waits, so this cycle is wait number wd_cnt+1
  assign expire = (TIMEOUT != 0) && stall && (wd_cnt == WD_LAST);

  always_comb begin
    next     = state;
    ir_we_c  = 1'b0;
    pc_we_c  = 1'b0;
    reg_we_c = 1'b0;
    mem_en_c = 1'b0;
    mem_we_c = 1'b0;
    done_c   = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_en_c = run;
        if (run && mem_ready) begin
          ir_we_c = 1'b1;
          next    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_class == CLS_ILLEGAL) begin
          pc_we_c = 1'b1;
          done_c  = 1'b1;
          next    = ST_FETCH;
        end else begin
          next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        case (class_q)
          CLS_BRANCH: begin
            pc_we_c = 1'b1;
            done_c  = 1'b1;
            next    = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: next = ST_MEMORY;
          default:             next = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        mem_en_c = 1'b1;
        mem_we_c = (class_q == CLS_STORE);
        if (mem_ready) begin
          if (class_q == CLS_STORE) begin
            pc_we_c = 1'b1;
            done_c  = 1'b1;
            next    = ST_FETCH;
          end else begin
            next = ST_WRITEBACK;
          end
        end else if (expire) begin
          // abandon the access: retire without touching the register file
          pc_we_c = 1'b1;
          done_c  = 1'b1;
          next    = ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        done_c   = 1'b1;
        next     = ST_FETCH;
      end
      default: next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      class_q <= CLS_ILLEGAL;
      wd_cnt  <= '0;
    end else begin
      state <= next;
      if (state == ST_DECODE) class_q <= dec_class;
      if (next != state || !stall || expire) wd_cnt <= '0;
      else                                   wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign ir_we       = ir_we_c  && !rst;
  assign pc_we       = pc_we_c  && !rst;
  assign reg_we      = reg_we_c && !rst;
  assign mem_en      = mem_en_c && !rst;
  assign mem_we      = mem_we_c && !rst;
  assign instr_done  = done_c   && !rst;
  assign mem_timeout = expire   && !rst;
  assign stage       = rst ? 3'd0 : state;

`ifdef SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_retired <= '0;
      stall_cycles  <= '0;
    end else begin
      if (done_c) instr_retired <= instr_retired + 32'd1;
      if (stall)  stall_cycles  <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer (TIMEOUT=4).
module tb_multicycle_sequencer;

  localparam int TO = 4;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [6:0] opcode = 7'h00;
  logic       mem_ready = 1'b0;
  logic       ir_we, pc_we, reg_we, mem_en, mem_we, instr_done, mem_timeout;
  logic [2:0] stage;
`ifdef SEQ_PERF_EN
  logic [31:0] instr_retired, stall_cycles;
`endif

  multicycle_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .mem_en(mem_en),
    .mem_we(mem_we), .stage(stage), .instr_done(instr_done),
`ifdef SEQ_PERF_EN
    .instr_retired(instr_retired), .stall_cycles(stall_cycles),
`endif
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { logic [2:0] st; logic rdy; } step_t;
  typedef struct { int cyc; logic regw; logic tmo; } exp_t;
  exp_t sbq[$];

  // 0 illegal, 1 branch, 2 load, 3 store, 4 alu
  function automatic int cls_of(input logic [6:0] o);
    case (o)
      7'b1100011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b0010011, 7'b0110011: return 4;
      default: return 0;
    endcase
  endfunction

  // fw = FETCH wait cycles, mw = MEMORY wait cycles (>= TO means watchdog expiry)
  task automatic do_instr(input logic [6:0] opc, input int fw, input int mw);
    step_t s[$];
    step_t t;
    exp_t  e;
    int    c = cls_of(opc);
    logic  tmo = 1'b0;
    for (int i = 0; i < fw; i++) begin t.st = F; t.rdy = 1'b0; s.push_back(t); end
    t.st = F; t.rdy = 1'b1; s.push_back(t);
    t.st = D; t.rdy = 1'($urandom); s.push_back(t);
    if (c != 0) begin
      t.st = E; t.rdy = 1'($urandom); s.push_back(t);
      if (c == 4) begin
        t.st = W; t.rdy = 1'($urandom); s.push_back(t);
      end else if (c >= 2) begin
        if (mw >= TO) begin
          tmo = 1'b1;
          for (int i = 0; i < TO; i++) begin t.st = M; t.rdy = 1'b0; s.push_back(t); end
        end else begin
          for (int i = 0; i < mw; i++) begin t.st = M; t.rdy = 1'b0; s.push_back(t); end
          t.st = M; t.rdy = 1'b1; s.push_back(t);
          if (c == 2) begin t.st = W; t.rdy = 1'($urandom); s.push_back(t); end
        end
      end
    end
    for (int i = 0; i < s.size(); i++) begin
      logic last;
      last = (i == s.size() - 1);
      @(posedge clk); #1;
      if (i == 0) begin
        e.cyc  = cyc + s.size() - 1;
        e.regw = (s[s.size()-1].st == W);
        e.tmo  = tmo;
        sbq.push_back(e);
      end
      run       = 1'b1;
      mem_ready = s[i].rdy;
      // opcode only meaningful in DECODE; scrambled elsewhere to prove latching
      opcode    = (s[i].st == D) ? opc : 7'($urandom);
      @(negedge clk);
      chk("stage",   stage,   s[i].st);
      chk("mem_en",  mem_en,  s[i].st == F || s[i].st == M);
      chk("mem_we",  mem_we,  s[i].st == M && c == 3);
      chk("ir_we",   ir_we,   s[i].st == F && s[i].rdy);
      chk("reg_we",  reg_we,  s[i].st == W);
      chk("pc_we",   pc_we,   last);
      chk("done",    instr_done, last);
      chk("timeout", mem_timeout, last && tmo);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && instr_done) begin
      if (sbq.size() == 0) chk("unexpected_retire", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("retire_cycle",  cyc,         e.cyc);
        chk("retire_reg_we", reg_we,      e.regw);
        chk("retire_tmo",    mem_timeout, e.tmo);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {ir_we, pc_we, reg_we, mem_en, mem_we, instr_done, mem_timeout, stage}, 0);
  endtask

  initial begin
    logic [31:0] st0, rt0;
    // reset
    run = 1'b1; mem_ready = 1'b1;
    repeat (2) begin @(negedge clk); chk_all_zero("reset"); end
    @(posedge clk); #1; rst = 1'b0; run = 1'b0;
    @(negedge clk);
    chk("post_rst_stage", stage, 0);
    chk("post_rst_mem_en", mem_en, 0);
`ifdef SEQ_PERF_EN
    chk("perf_rst_ret", instr_retired, 0);
    chk("perf_rst_stall", stall_cycles, 0);
`endif

    do_instr(7'b0110011, 0, 0);               // ADD
`ifdef SEQ_PERF_EN
    st0 = stall_cycles; rt0 = instr_retired;
`else
    st0 = 0; rt0 = 0;
`endif
    do_instr(7'b0000011, 0, 3);               // LW, 3 MEMORY stalls
`ifdef SEQ_PERF_EN
    chk("perf_stall_lw", stall_cycles - st0, 3);
    chk("perf_ret_lw", instr_retired - rt0, 1);
`endif
    do_instr(7'b1100011, 0, 0);               // BEQ
    do_instr(7'b0000000, 0, 0);               // illegal
    do_instr(7'b0100011, 0, 99);              // SW, watchdog expiry
    do_instr(7'b0010011, 2, 0);               // OPIMM after fetch stalls
    do_instr(7'b0100011, 0, 1);               // SW
    do_instr(7'b0000011, 1, 0);               // LW
    do_instr(7'b1111111, 1, 0);               // illegal

    // reset while in WRITEBACK drops the ADD
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      run = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
    end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_in_wb");
    @(posedge clk); #1; rst = 1'b0; run = 1'b0;
    @(negedge clk);
    chk("rst_wb_stage", stage, 0);
    chk("rst_wb_done", instr_done, 0);

    // run low holds FETCH idle
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; run = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      chk("idle_mem_en", mem_en, 0);
      chk("idle_ir_we", ir_we, 0);
      chk("idle_stage", stage, 0);
    end
    do_instr(7'b0110011, 0, 0);

    for (int k = 0; k < 12; k++) begin
      logic [6:0] ops [6];
      ops = '{7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1010101};
      do_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 5));
    end

    @(posedge clk); #1; run = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
